// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures one period, high time and fractional duty of an async waveform
// Ports: clk/rst (async, active-high); en enables measuring; sig_in is the raw waveform;
// meas_valid/meas_ready hand off period, high_time, duty (high_time*2^FRAC_W/period)
// and the stuck_hi/stuck_lo timeout flags.
module pwm_duty_meter #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sig_in,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [FRAC_W-1:0] duty,
  output logic              stuck_hi,
  output logic              stuck_lo
);
  localparam int RW = CNT_W + 1;
  localparam int SW = $clog2(FRAC_W + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  typedef enum logic [2:0] {IDLE, ARM, MEAS_HI, MEAS_LO, DIVIDE, HOLD} state_t;
  state_t state_q, state_d;
  logic s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_p_q, cnt_p_d, cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [FRAC_W-1:0] duty_q, duty_d, quo_q, quo_d, quo_nx;
  logic [RW-1:0] rem_q, rem_d, rem_nx;
  logic [RW:0] rem_sh, rem_sub;
  logic [SW-1:0] step_q, step_d;
  logic valid_q, valid_d, stuck_hi_q, stuck_hi_d, stuck_lo_q, stuck_lo_d;
  logic rise, fall, tmo, ge;
  always_comb begin
    state_d    = state_q;
    cnt_p_d    = cnt_p_q;
    cnt_h_d    = cnt_h_q;
    period_d   = period_q;
    high_d     = high_q;
    duty_d     = duty_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    step_d     = step_q;
    valid_d    = valid_q;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;
    s1_d       = sig_in;
    s2_d       = s1_q;
    prev_d     = s2_q;
    rise       = s2_q & ~prev_q;
    fall       = ~s2_q & prev_q;
    tmo        = cnt_p_q == MAX;
    // Remainder never exceeds period, so doubling it always fits in RW bits;
    // high_time == period keeps the remainder at period and saturates duty to all-ones.
    rem_sh     = {rem_q, 1'b0};
    rem_sub    = rem_sh - {2'b00, period_q};
    ge         = rem_sh >= {2'b00, period_q};
    rem_nx     = RW'(ge ? rem_sub : rem_sh);
    quo_nx     = (quo_q << 1) | FRAC_W'(ge);
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = ARM;
          cnt_p_d = '0;
          cnt_h_d = '0;
        end
      end
      ARM, MEAS_HI, MEAS_LO: begin
        if (!en) begin
          state_d    = IDLE;
          stuck_hi_d = 1'b0;
          stuck_lo_d = 1'b0;
        end else if (state_q == ARM && rise) begin
          cnt_p_d = CNT_W'(1);
          cnt_h_d = CNT_W'(1);
          state_d = MEAS_HI;
        end else if (state_q == MEAS_LO && rise) begin
          period_d = cnt_p_q;
          high_d   = cnt_h_q;
          rem_d    = RW'(cnt_h_q);
          quo_d    = '0;
          step_d   = '0;
          state_d  = DIVIDE;
        end else if (tmo) begin
          period_d   = MAX;
          high_d     = state_q == ARM ? (s2_q ? MAX : '0) : cnt_h_q;
          rem_d      = RW'(high_d);
          quo_d      = '0;
          step_d     = '0;
          stuck_hi_d = s2_q;
          stuck_lo_d = ~s2_q;
          state_d    = DIVIDE;
        end else if (state_q == ARM) begin
          cnt_p_d = cnt_p_q + CNT_W'(1);
        end else begin
          cnt_p_d = cnt_p_q + CNT_W'(1);
          cnt_h_d = cnt_h_q + CNT_W'(s2_q);
          state_d = fall ? MEAS_LO : state_q;
        end
      end
      DIVIDE: begin
        if (!en) begin
          state_d    = IDLE;
          stuck_hi_d = 1'b0;
          stuck_lo_d = 1'b0;
        end else begin
          rem_d  = rem_nx;
          quo_d  = quo_nx;
          step_d = step_q + SW'(1);
          if (step_q == SW'(FRAC_W - 1)) begin
            duty_d  = quo_nx;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (meas_ready) begin
          valid_d    = 1'b0;
          stuck_hi_d = 1'b0;
          stuck_lo_d = 1'b0;
          cnt_p_d    = '0;
          cnt_h_d    = '0;
          state_d    = en ? ARM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      prev_q     <= 1'b0;
      cnt_p_q    <= '0;
      cnt_h_q    <= '0;
      period_q   <= '0;
      high_q     <= '0;
      duty_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      step_q     <= '0;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      cnt_p_q    <= cnt_p_d;
      cnt_h_q    <= cnt_h_d;
      period_q   <= period_d;
      high_q     <= high_d;
      duty_q     <= duty_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      step_q     <= step_d;
      valid_q    <= valid_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end
  assign meas_valid = valid_q;
  assign period     = period_q;
  assign high_time  = high_q;
  assign duty       = duty_q;
  assign stuck_hi   = stuck_hi_q;
  assign stuck_lo   = stuck_lo_q;
endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: directed stimulus with a result queue checked by an independent monitor
module tb_pwm_duty_meter;
  localparam int CW = 12;
  localparam int FW = 8;
  localparam logic [CW-1:0] ALL1 = '1;
  typedef struct packed {
    logic [CW-1:0] p;
    logic [CW-1:0] h;
    logic [FW-1:0] d;
    logic          sh;
    logic          sl;
  } res_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sig_in = 1'b0, meas_ready = 1'b0;
  logic meas_valid, stuck_hi, stuck_lo;
  logic [CW-1:0] period, high_time;
  logic [FW-1:0] duty;
  pwm_duty_meter #(.CNT_W(CW), .FRAC_W(FW)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .meas_valid(meas_valid), .meas_ready(meas_ready),
    .period(period), .high_time(high_time), .duty(duty),
    .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic wave_on = 1'b0, lvl = 1'b0, nxt;
  int hi = 1, per = 4, ph = 0, last_rise = 0;
  always begin
    @(posedge clk);
    #2;
    if (wave_on) begin
      ph = (ph + 1 >= per) ? 0 : ph + 1;
      nxt = ph < hi;
    end else nxt = lvl;
    if (nxt && !sig_in) last_rise = cyc;
    sig_in = nxt;
  end
  res_t exp_q[$];
  res_t mon_e;
  int checks = 0, failures = 0, xfers = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && meas_valid && meas_ready) begin
      xfers++;
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("period", period, mon_e.p);
        check("high_time", high_time, mon_e.h);
        check("duty", duty, mon_e.d);
        check("stuck_hi", stuck_hi, mon_e.sh);
        check("stuck_lo", stuck_lo, mon_e.sl);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input int n);
    lvl = v;
    repeat (n) tick();
  endtask
  task automatic wait_xfer(input int target, input int budget, input string name);
    int n = 0;
    while (xfers < target && n < budget) begin
      tick();
      n++;
    end
    check(name, xfers, target);
  endtask
  int n, lat, vcount;
  initial begin
    repeat (3) tick();
    check("rst_valid", meas_valid, 0);
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_duty", duty, 0);
    check("rst_stuck_hi", stuck_hi, 0);
    check("rst_stuck_lo", stuck_lo, 0);
    rst = 1'b0;
    repeat (2) tick();
    hi = 1; per = 4; wave_on = 1'b1; meas_ready = 1'b1;
    repeat (8) tick();
    exp_q.push_back('{12'd4, 12'd1, 8'h40, 1'b0, 1'b0});
    en = 1'b1;
    wait_xfer(1, 100, "xfer_quarter");
    en = 1'b0;
    wave_on = 1'b0; lvl = 1'b0;
    repeat (6) tick();
    exp_q.push_back('{12'd7, 12'd3, 8'h6D, 1'b0, 1'b0});
    en = 1'b1;
    drive(1'b0, 3);
    drive(1'b1, 3);
    drive(1'b0, 4);
    lvl = 1'b1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (meas_valid) begin
        lat = cyc - last_rise;
        break;
      end
    end
    check("latency", lat, 11);
    wait_xfer(2, 20, "xfer_3of7");
    en = 1'b0;
    lvl = 1'b0;
    repeat (4) tick();
    exp_q.push_back('{ALL1, ALL1, 8'hFF, 1'b1, 1'b0});
    en = 1'b1;
    drive(1'b0, 3);
    lvl = 1'b1;
    wait_xfer(3, 6000, "xfer_stuck_hi");
    check("stuck_hi_cleared", stuck_hi, 0);
    en = 1'b0;
    lvl = 1'b0;
    repeat (4) tick();
    exp_q.push_back('{ALL1, 12'd0, 8'h00, 1'b0, 1'b1});
    en = 1'b1;
    wait_xfer(4, 6000, "xfer_stuck_lo");
    check("stuck_lo_cleared", stuck_lo, 0);
    en = 1'b0;
    meas_ready = 1'b0;
    hi = 2; per = 5; wave_on = 1'b1;
    repeat (8) tick();
    exp_q.push_back('{12'd5, 12'd2, 8'h66, 1'b0, 1'b0});
    exp_q.push_back('{12'd5, 12'd2, 8'h66, 1'b0, 1'b0});
    en = 1'b1;
    n = 0;
    while (!meas_valid && n < 100) begin
      tick();
      n++;
    end
    check("bp_valid_seen", meas_valid, 1);
    repeat (20) begin
      tick();
      check("bp_hold", {meas_valid, period, high_time, duty, stuck_hi, stuck_lo},
            {1'b1, 12'd5, 12'd2, 8'h66, 2'b00});
    end
    meas_ready = 1'b1;
    wait_xfer(5, 10, "xfer_bp_first");
    wait_xfer(6, 100, "xfer_bp_next");
    en = 1'b0;
    wave_on = 1'b0; lvl = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    drive(1'b0, 3);
    drive(1'b1, 2);
    drive(1'b0, 5);
    en = 1'b0;
    vcount = 0;
    repeat (30) begin
      tick();
      if (meas_valid) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    check("abort_no_xfer", xfers, 6);
    hi = 4; per = 8; wave_on = 1'b1;
    repeat (8) tick();
    exp_q.push_back('{12'd8, 12'd4, 8'h80, 1'b0, 1'b0});
    en = 1'b1;
    wait_xfer(7, 100, "xfer_half");
    en = 1'b0;
    wave_on = 1'b0; lvl = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 3);
    lvl = 1'b1;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("rstdiv_valid", meas_valid, 0);
    check("rstdiv_period", period, 0);
    check("rstdiv_high", high_time, 0);
    check("rstdiv_duty", duty, 0);
    en = 1'b0;
    lvl = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    hi = 1; per = 4; wave_on = 1'b1;
    repeat (8) tick();
    exp_q.push_back('{12'd4, 12'd1, 8'h40, 1'b0, 1'b0});
    en = 1'b1;
    wait_xfer(8, 100, "xfer_after_rst");
    en = 1'b0;
    repeat (5) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
Measures one period of an asynchronous pulse or divided-clock signal against the system clock, and reports its period, high time and fractional duty cycle. It is the receive/analysis side for the team's clock-divider and duty-cycle generator blocks: it turns a waveform back into numbers. A valid/ready interface delivers results to a status register or host bus.

Parameters:
CNT_W, 16, width of the period and high-time counters (clk cycles)
FRAC_W, 8, width of the duty result; duty = floor(high_time * 2^FRAC_W / period)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  measurement enable (level)
sig_in  in  1  asynchronous input waveform
meas_valid  out  1  result valid, held until accepted
meas_ready  in  1  consumer ready
period  out  CNT_W  clk cycles between two rising edges of the synchronised input
high_time  out  CNT_W  clk cycles the synchronised input was high within that period
duty  out  FRAC_W  fractional duty cycle
stuck_hi  out  1  timeout with the input high
stuck_lo  out  1  timeout with the input low

Behaviour:
- Reset (async, rst=1): FSM to IDLE. Counters and all outputs are 0, including meas_valid, period, high_time, duty, stuck_hi and stuck_lo. Synchroniser flops and prev flop are 0.
- Sync: 2-flop synchroniser gives sig_s, which is sig_in delayed 2 clk.
- prev flop holds the last sig_s. rise = sig_s & ~prev; fall = ~sig_s & prev.
- FSM states: IDLE, ARM, MEAS_HI, MEAS_LO, DIVIDE, HOLD.
- IDLE: if en=1, go to ARM next cycle and clear cnt_p (period counter) and cnt_h (high counter).
- ARM: wait for rise.
  - On rise: cnt_p=1, cnt_h=1, go to MEAS_HI.
  - In ARM, cnt_p increments every cycle as a timeout counter.
- MEAS_HI / MEAS_LO: each cycle without a closing rise, cnt_p++. cnt_h++ when sig_s=1.
  - fall moves MEAS_HI to MEAS_LO.
  - A rise in MEAS_LO closes the period. That cycle is not counted. period<=cnt_p, high_time<=cnt_h, go to DIVIDE.
  - Example: sig_s = 1,0,0,0,1 gives period=4, high_time=1.
- Timeout: if cnt_p == 2^CNT_W-1 in ARM, MEAS_HI or MEAS_LO with no closing rise:
  - period <= all-ones.
  - high_time <= cnt_h if measuring. In ARM, high_time <= all-ones if sig_s=1, else 0.
  - stuck_hi <= sig_s; stuck_lo <= ~sig_s. Go to DIVIDE.
  - Counters never wrap.
- DIVIDE: restoring fraction divider.
  - Start: r=high_time (CNT_W+1 bits), q=0.
  - Each step: r=2r. If r>=period, set the q bit and r-=period. MSB first.
  - Exactly FRAC_W cycles, then HOLD.
  - If high_time==period, duty = 2^FRAC_W-1 (saturate). The cycle count stays FRAC_W.
  - If high_time==0, duty=0.
- HOLD: meas_valid=1. period, high_time, duty and stuck flags stay stable while meas_valid=1.
  - Transfer happens on a cycle with meas_valid&meas_ready.
  - Next cycle: meas_valid=0, stuck flags cleared, go to ARM if en=1, else IDLE. Data outputs keep their last value.
  - meas_ready is ignored outside HOLD.
- Measurements are one-shot: each new result needs a fresh rise seen in ARM after the handshake.
- en=0 in ARM, MEAS_HI, MEAS_LO or DIVIDE: abort to IDLE next cycle and produce no result.
- en=0 in HOLD: the pending result stays until accepted, then go to IDLE.
- Latency: meas_valid asserts FRAC_W+1 clk after the closing-rise cycle.
- Simultaneous events:
  - Timeout and closing rise in the same cycle: the rise wins (normal result, no stuck flag).
  - rst mid-operation overrides everything.

Test Plan:
- 25% wave (1 clk high of 4, from a divided clock), en=1, meas_ready=1 -> period=4, high_time=1, duty=0x40, stuck flags 0.
- 3 high / 7 period -> period=7, high_time=3, duty=109 (0x6D). meas_valid exactly FRAC_W+1=9 clk after the closing rise.
- sig_in goes high after a rise and stays high -> at cnt_p=0xFFFF: period=0xFFFF, high_time=0xFFFF, duty=0xFF, stuck_hi=1. sig_in held 0 from reset -> period=0xFFFF, high_time=0, duty=0, stuck_lo=1.
- Backpressure: meas_ready=0 for 20 clk during HOLD while sig_in keeps toggling -> meas_valid and outputs stable. After ready=1, one transfer, then the next measurement starts from ARM.
- Abort: en dropped mid-MEAS_LO -> no meas_valid, FSM in IDLE. Re-enable with 50% wave, 8 clk period -> period=8, high_time=4, duty=0x80.
- rst asserted mid-DIVIDE -> all outputs 0 immediately (async). After release with en=1, the next measurement is correct.
